// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: turns load-use, divide, jump, halt and bus back-pressure
// hazards into hold/stall/flush controls for the PC, IF/ID and ID/EX registers.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_raddr_i,
    input  logic             id_rs1_re_i,
    input  logic [4:0]       id_rs2_raddr_i,
    input  logic             id_rs2_re_i,
    input  logic             ex_is_load_i,
    input  logic             ex_reg_we_i,
    input  logic [4:0]       ex_reg_waddr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             div_start_i,
    input  logic             div_ready_i,
    input  logic             bus_hold_i,
    input  logic             halt_req_i,
    output logic [2:0]       hold_flag_o,
    output logic             stall_flag_o,
    output logic             flush_if_o,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic             halt_ack_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    state_e           state_q, state_d;
    logic             halt_ack_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             rs1_hit, rs2_hit, load_use;

    assign rs1_hit  = id_rs1_re_i && (id_rs1_raddr_i == ex_reg_waddr_i);
    assign rs2_hit  = id_rs2_re_i && (id_rs2_raddr_i == ex_reg_waddr_i);
    assign load_use = ex_is_load_i && ex_reg_we_i && (ex_reg_waddr_i != 5'd0)
                      && (rs1_hit || rs2_hit);

    // A jump never moves the FSM by itself; only the divider and halt level do.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (div_start_i) begin
                    state_d = DIV_WAIT;
                end else if (halt_req_i && !jump_flag_i) begin
                    state_d = HALT;
                end
            end
            DIV_WAIT: begin
                if (div_ready_i) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (!halt_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_flag_o  = HOLD_NONE;
        stall_flag_o = 1'b0;
        flush_if_o   = 1'b0;
        jump_flag_o  = 1'b0;
        jump_addr_o  = 32'd0;
        if (!rst) begin
            if (jump_flag_i) begin
                hold_flag_o  = HOLD_ID;
                flush_if_o   = 1'b1;
                jump_flag_o  = 1'b1;
                jump_addr_o  = jump_addr_i;
                stall_flag_o = (state_q == DIV_WAIT);
            end else if ((state_q == DIV_WAIT) && !div_ready_i) begin
                hold_flag_o  = HOLD_IF;
                stall_flag_o = 1'b1;
            end else if (state_q == HALT) begin
                hold_flag_o = HOLD_ID;
            end else if (load_use) begin
                hold_flag_o = HOLD_ID;
            end else if (bus_hold_i) begin
                hold_flag_o = HOLD_PC;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((hold_flag_o != HOLD_NONE) || stall_flag_o) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // halt_ack follows the registered state, so it lags HALT entry/exit by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            halt_ack_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_ack_q  <= (state_q == HALT);
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halt_ack_o  = halt_ack_q;
    assign stall_cnt_o = stall_cnt_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, corner-case sequences and random
// stimulus against a flag-based reference model; two counter widths in parallel.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_reg_waddr;
    logic        id_rs1_re, id_rs2_re, ex_is_load, ex_reg_we;
    logic        jump_flag, div_start, div_ready, bus_hold, halt_req;
    logic [31:0] jump_addr;

    logic [2:0]  hold_flag_o;
    logic        stall_flag_o, flush_if_o, jump_flag_o, halt_ack_o;
    logic [31:0] jump_addr_o;
    logic [7:0]  stall_cnt_o;
    logic [1:0]  state_dbg_o;

    logic [2:0]  s_hold;
    logic        s_stall, s_flush, s_jf, s_ack;
    logic [31:0] s_jaddr;
    logic [3:0]  s_cnt;
    logic [1:0]  s_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1_raddr_i(id_rs1_raddr), .id_rs1_re_i(id_rs1_re),
        .id_rs2_raddr_i(id_rs2_raddr), .id_rs2_re_i(id_rs2_re),
        .ex_is_load_i(ex_is_load), .ex_reg_we_i(ex_reg_we), .ex_reg_waddr_i(ex_reg_waddr),
        .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .div_start_i(div_start), .div_ready_i(div_ready),
        .bus_hold_i(bus_hold), .halt_req_i(halt_req),
        .hold_flag_o(hold_flag_o), .stall_flag_o(stall_flag_o), .flush_if_o(flush_if_o),
        .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .halt_ack_o(halt_ack_o),
        .stall_cnt_o(stall_cnt_o), .state_dbg_o(state_dbg_o)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs1_raddr_i(id_rs1_raddr), .id_rs1_re_i(id_rs1_re),
        .id_rs2_raddr_i(id_rs2_raddr), .id_rs2_re_i(id_rs2_re),
        .ex_is_load_i(ex_is_load), .ex_reg_we_i(ex_reg_we), .ex_reg_waddr_i(ex_reg_waddr),
        .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .div_start_i(div_start), .div_ready_i(div_ready),
        .bus_hold_i(bus_hold), .halt_req_i(halt_req),
        .hold_flag_o(s_hold), .stall_flag_o(s_stall), .flush_if_o(s_flush),
        .jump_flag_o(s_jf), .jump_addr_o(s_jaddr), .halt_ack_o(s_ack),
        .stall_cnt_o(s_cnt), .state_dbg_o(s_state)
    );

    // Reference model: divider busy / core halted flags and plain integer counters.
    bit          m_busy, m_halted, m_ack;
    int          m_cnt8, m_cnt4;
    logic [2:0]  e_hold;
    logic        e_stall, e_flush, e_jf;
    logic [31:0] e_jaddr;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_load_use();
        bit hit1, hit2;
        hit1 = id_rs1_re && (id_rs1_raddr == ex_reg_waddr);
        hit2 = id_rs2_re && (id_rs2_raddr == ex_reg_waddr);
        return ex_is_load && ex_reg_we && (ex_reg_waddr != 0) && (hit1 || hit2);
    endfunction

    task automatic model_comb();
        e_hold = 0; e_stall = 0; e_flush = 0; e_jf = 0; e_jaddr = 0;
        if (rst) begin
            e_hold = 0;
        end else if (jump_flag) begin
            e_hold = 3; e_flush = 1; e_jf = 1; e_jaddr = jump_addr; e_stall = m_busy;
        end else if (m_busy && !div_ready) begin
            e_hold = 2; e_stall = 1;
        end else if (m_halted) begin
            e_hold = 3;
        end else if (model_load_use()) begin
            e_hold = 3;
        end else if (bus_hold) begin
            e_hold = 1;
        end
    endtask

    task automatic model_seq();
        if (rst) begin
            m_busy = 0; m_halted = 0; m_ack = 0; m_cnt8 = 0; m_cnt4 = 0;
        end else begin
            m_ack = m_halted;
            if (e_hold != 0 || e_stall) begin
                m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
                m_cnt4 = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
            end
            if (m_busy) begin
                if (div_ready) m_busy = 0;
            end else if (m_halted) begin
                if (!halt_req) m_halted = 0;
            end else if (div_start) begin
                m_busy = 1;
            end else if (halt_req && !jump_flag) begin
                m_halted = 1;
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs are compared 1 time unit later.
    task automatic run_cycle();
        model_comb();
        #1;
        check("hold", hold_flag_o, e_hold);
        check("stall", stall_flag_o, e_stall);
        check("flush_if", flush_if_o, e_flush);
        check("jump_flag", jump_flag_o, e_jf);
        check("jump_addr", jump_addr_o, e_jaddr);
        check("halt_ack", halt_ack_o, m_ack);
        check("stall_cnt8", stall_cnt_o, m_cnt8);
        check("stall_cnt4", s_cnt, m_cnt4);
        check("state", state_dbg_o, m_busy ? 1 : (m_halted ? 2 : 0));
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst = 0; id_rs1_raddr = 0; id_rs1_re = 0; id_rs2_raddr = 0; id_rs2_re = 0;
        ex_is_load = 0; ex_reg_we = 0; ex_reg_waddr = 0; jump_flag = 0; jump_addr = 0;
        div_start = 0; div_ready = 0; bus_hold = 0; halt_req = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        run_cycle();
        rst = 0;
    endtask

    task automatic expect_now(string name, logic [2:0] hold, logic stall);
        #1;
        check({name, ".hold"}, hold_flag_o, hold);
        check({name, ".stall"}, stall_flag_o, stall);
    endtask

    typedef struct {
        string       name;
        logic [4:0]  rs1;
        logic        rs1_re;
        logic [4:0]  rs2;
        logic        rs2_re;
        logic        ld;
        logic        we;
        logic [4:0]  wa;
        logic        jmp;
        logic [31:0] ja;
        logic        bus;
        logic [2:0]  e_hold;
        logic        e_flush;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{"lu_rs2",    5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 32'h0,     1'b0, 3'd3, 1'b0};
        vt[1] = '{"lu_rs1",    5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 32'h0,     1'b0, 3'd3, 1'b0};
        vt[2] = '{"ld_x0",     5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0,     1'b0, 3'd0, 1'b0};
        vt[3] = '{"no_read",   5'd5, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 32'h0,     1'b0, 3'd0, 1'b0};
        vt[4] = '{"not_load",  5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0,     1'b0, 3'd0, 1'b0};
        vt[5] = '{"no_we",     5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 32'h0,     1'b0, 3'd0, 1'b0};
        vt[6] = '{"jump_lu",   5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 32'h100,   1'b0, 3'd3, 1'b1};
        vt[7] = '{"bus",       5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,     1'b1, 3'd1, 1'b0};
        vt[8] = '{"bus_lu",    5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 32'h0,     1'b1, 3'd3, 1'b0};
        vt[9] = '{"quiet",     5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'hdead, 1'b0, 3'd0, 1'b0};

        set_idle();
        rst = 1;
        m_busy = 0; m_halted = 0; m_ack = 0; m_cnt8 = 0; m_cnt4 = 0;
        @(negedge clk);
        do_reset();

        // Single-cycle vectors from IDLE
        for (int i = 0; i < 10; i++) begin
            id_rs1_raddr = vt[i].rs1; id_rs1_re = vt[i].rs1_re;
            id_rs2_raddr = vt[i].rs2; id_rs2_re = vt[i].rs2_re;
            ex_is_load = vt[i].ld; ex_reg_we = vt[i].we; ex_reg_waddr = vt[i].wa;
            jump_flag = vt[i].jmp; jump_addr = vt[i].ja; bus_hold = vt[i].bus;
            #1;
            check({vt[i].name, ".hold"}, hold_flag_o, vt[i].e_hold);
            check({vt[i].name, ".flush"}, flush_if_o, vt[i].e_flush);
            check({vt[i].name, ".jf"}, jump_flag_o, vt[i].jmp);
            check({vt[i].name, ".jaddr"}, jump_addr_o, vt[i].jmp ? vt[i].ja : 32'd0);
            run_cycle();
        end

        // Load-use: one bubble, then EX holds the bubble
        do_reset();
        id_rs2_raddr = 5; id_rs2_re = 1; ex_is_load = 1; ex_reg_we = 1; ex_reg_waddr = 5;
        expect_now("lu_bubble", 3, 0);
        check("lu_bubble.flush", flush_if_o, 0);
        run_cycle();
        ex_is_load = 0; ex_reg_we = 0; ex_reg_waddr = 0;
        expect_now("lu_after", 0, 0);
        check("lu_after.cnt", stall_cnt_o, 1);
        run_cycle();

        // Divide: start, 32 stall cycles, ready
        do_reset();
        div_start = 1;
        expect_now("div_start", 0, 0);
        run_cycle();
        div_start = 0;
        for (int i = 0; i < 32; i++) begin
            expect_now("div_wait", 2, 1);
            run_cycle();
        end
        div_ready = 1;
        expect_now("div_ready", 0, 0);
        run_cycle();
        div_ready = 0;
        #1;
        check("div_cnt", stall_cnt_o, 32);
        run_cycle();

        // Start and ready together still enters DIV_WAIT
        do_reset();
        div_start = 1; div_ready = 1;
        run_cycle();
        div_start = 0; div_ready = 0;
        expect_now("div_same_wait", 2, 1);
        run_cycle();
        div_ready = 1;
        run_cycle();
        div_ready = 0;
        expect_now("div_same_exit", 0, 0);
        run_cycle();

        // Halt held for 5 cycles from IDLE
        do_reset();
        halt_req = 1;
        for (int i = 0; i < 5; i++) begin
            expect_now("halt_in", (i == 0) ? 3'd0 : 3'd3, 0);
            check("halt_in.ack", halt_ack_o, (i >= 2) ? 1 : 0);
            run_cycle();
        end
        halt_req = 0;
        expect_now("halt_rel0", 3, 0);
        check("halt_rel0.ack", halt_ack_o, 1);
        run_cycle();
        expect_now("halt_rel1", 0, 0);
        check("halt_rel1.ack", halt_ack_o, 1);
        run_cycle();
        check("halt_rel2.ack", halt_ack_o, 0);
        run_cycle();

        // Halt request during a divide waits for IDLE
        do_reset();
        div_start = 1;
        run_cycle();
        div_start = 0; halt_req = 1;
        expect_now("halt_defer_div", 2, 1);
        run_cycle();
        div_ready = 1;
        expect_now("halt_defer_rdy", 0, 0);
        run_cycle();
        div_ready = 0;
        expect_now("halt_defer_idle", 0, 0);
        run_cycle();
        expect_now("halt_defer_halt", 3, 0);
        run_cycle();
        halt_req = 0;
        run_cycle();
        run_cycle();

        // Counter saturation on the 4-bit instance
        do_reset();
        bus_hold = 1;
        for (int i = 0; i < 20; i++) run_cycle();
        bus_hold = 0;
        #1;
        check("sat_cnt4", s_cnt, 15);
        check("sat_cnt8", stall_cnt_o, 20);
        run_cycle();

        // Reset while dividing
        do_reset();
        div_start = 1;
        run_cycle();
        div_start = 0;
        run_cycle();
        rst = 1;
        expect_now("rst_in_div", 0, 0);
        run_cycle();
        rst = 0;
        expect_now("rst_after", 0, 0);
        check("rst_after.cnt8", stall_cnt_o, 0);
        check("rst_after.cnt4", s_cnt, 0);
        run_cycle();

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            id_rs1_raddr = 5'($urandom_range(0, 3));
            id_rs2_raddr = 5'($urandom_range(0, 3));
            ex_reg_waddr = 5'($urandom_range(0, 3));
            id_rs1_re    = 1'($urandom_range(0, 1));
            id_rs2_re    = 1'($urandom_range(0, 1));
            ex_is_load   = 1'($urandom_range(0, 1));
            ex_reg_we    = 1'($urandom_range(0, 1));
            jump_flag    = ($urandom_range(0, 5) == 0);
            jump_addr    = $urandom;
            div_start    = ($urandom_range(0, 9) == 0);
            div_ready    = ($urandom_range(0, 7) == 0);
            bus_hold     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
